// File: rtl/dictionary_loader.sv
// dictionary_loader
//   Stages a dictionary load from a stallable source into an internal buffer,
//   then replays it as one uninterrupted write_enable burst starting at index 0.
//   The downstream dictionary clears its write index on any cycle without
//   write_enable, so the burst must never contain a gap.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   start          : begin a load (honoured only in IDLE)
//   in_valid/in_data/in_last/in_ready : source beat handshake
//   write_enable, write_val           : dictionary write port
//   busy           : not IDLE
//   done           : one-cycle pulse after the burst completes
//   count          : entries accepted in the current/most recent load
module dictionary_loader #(
  parameter int KEY_WIDTH = 5,
  parameter int VAL_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [VAL_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 write_enable,
  output logic [VAL_WIDTH-1:0] write_val,
  output logic                 busy,
  output logic                 done,
  output logic [KEY_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** KEY_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    BURST,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [KEY_WIDTH:0]     count_q, count_d;
  logic [KEY_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic [VAL_WIDTH-1:0]   buf_q [DEPTH];
  logic                   buf_we;
  logic [KEY_WIDTH-1:0]   buf_waddr;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_idx_d     = rd_idx_q;
    in_ready     = 1'b0;
    write_enable = 1'b0;
    write_val    = '0;
    busy         = (state_q != IDLE);
    done         = 1'b0;
    buf_we       = 1'b0;
    buf_waddr    = count_q[KEY_WIDTH-1:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d  = '0;
          rd_idx_d = '0;
          state_d  = FILL;
        end
      end
      FILL: begin
        // FILL is left as soon as the buffer holds DEPTH entries, so in_ready
        // can stay high for the whole state and count never exceeds DEPTH.
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we   = 1'b1;
          count_d  = count_q + 1'b1;
          rd_idx_d = '0;
          if (in_last || (count_q == (KEY_WIDTH+1)'(DEPTH - 1))) begin
            state_d = BURST;
          end
        end
      end
      BURST: begin
        write_enable = 1'b1;
        write_val    = buf_q[rd_idx_q];
        if ({1'b0, rd_idx_q} == (count_q - 1'b1)) begin
          state_d = DONE;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Staging buffer carries no reset; stale entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_waddr] <= in_data;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_dictionary_loader.sv
// tb_dictionary_loader
//   Directed bench for dictionary_loader. A behavioural dictionary (index
//   advances while write_enable is high, clears on any low cycle) records the
//   writes so that gaps or misordering show up as wrong stored contents.
module tb_dictionary_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [9:0]  in_data;
  logic        in_ready, write_enable, busy, done;
  logic [9:0]  write_val;
  logic [5:0]  count;

  int checks   = 0;
  int failures = 0;

  logic [9:0]  dict [32];
  logic [4:0]  widx;
  int          done_cnt;
  logic        dict_clear;
  int          exp_vals [32];
  int          done_before;

  always #5 clk = ~clk;

  dictionary_loader #(.KEY_WIDTH(5), .VAL_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .write_enable(write_enable), .write_val(write_val), .busy(busy),
    .done(done), .count(count)
  );

  always @(posedge clk) begin
    if (dict_clear) begin
      for (int i = 0; i < 32; i++) dict[i] <= 10'h155;
      widx     <= '0;
      done_cnt <= 0;
    end else begin
      if (write_enable) begin
        dict[widx] <= write_val;
        widx       <= widx + 1'b1;
      end else begin
        widx <= '0;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_count", count, 0);
    chk("start_ready", in_ready, 1);
  endtask

  task automatic beat(input logic [9:0] v, input logic last);
    in_valid = 1'b1;
    in_data  = v;
    in_last  = last;
    chk("beat_ready", in_ready, 1);
    chk("fill_we", write_enable, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Called on the first burst cycle (the negedge right after the last beat).
  task automatic burst_check(input int n, input bit poke);
    for (int j = 0; j < n; j++) begin
      chk("burst_we", write_enable, 1);
      chk("burst_val", write_val, exp_vals[j]);
      chk("burst_ready", in_ready, 0);
      start = poke && (j == 1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_we", write_enable, 0);
    chk("done_val", write_val, 0);
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("final_count", count, n);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    dict_clear = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_val", write_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    start = 1'b1;
    @(negedge clk);
    chk("rst_beats_start", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    dict_clear = 1'b0;
    @(negedge clk);

    // Full load: 32 beats 0x000..0x01F, in_last on beat 32.
    do_start();
    for (int i = 0; i < 32; i++) begin
      exp_vals[i] = i;
      beat(10'(i), i == 31);
    end
    burst_check(32, 1'b0);
    for (int i = 0; i < 32; i++) chk("full_dict", dict[i], i);
    repeat (3) @(negedge clk);
    chk("count_hold", count, 32);
    chk("done_cnt_1", done_cnt, 1);

    // Partial load with start pokes during FILL and BURST.
    do_start();
    beat(10'h3A0, 1'b0);
    beat(10'h3A1, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fill_start_count", count, 2);
    chk("fill_start_busy", busy, 1);
    beat(10'h3A2, 1'b0);
    beat(10'h3A3, 1'b0);
    for (int i = 0; i < 5; i++) exp_vals[i] = 'h3A0 + i;
    beat(10'h3A4, 1'b1);
    burst_check(5, 1'b1);
    chk("part_dict0", dict[0], 'h3A0);
    chk("part_dict4", dict[4], 'h3A4);
    chk("part_dict5", dict[5], 5);
    chk("part_dict31", dict[31], 31);
    @(negedge clk);
    chk("done_cnt_2", done_cnt, 2);

    // Stalled source: 3 idle cycles between beats.
    do_start();
    for (int i = 0; i < 8; i++) begin
      exp_vals[i] = 'h0C0 + i;
      beat(10'('h0C0 + i), i == 7);
      if (i != 7) begin
        for (int s = 0; s < 3; s++) begin
          chk("stall_we", write_enable, 0);
          @(negedge clk);
        end
      end
    end
    burst_check(8, 1'b0);
    chk("stall_dict7", dict[7], 'h0C7);
    chk("stall_dict8", dict[8], 8);
    chk("done_cnt_3", done_cnt, 3);

    // Overflow: 32 beats without in_last, beats 33/34 held on the bus.
    do_start();
    for (int i = 0; i < 32; i++) begin
      exp_vals[i] = 'h200 + i;
      beat(10'('h200 + i), 1'b0);
    end
    in_valid = 1'b1;
    in_data  = 10'h3FF;
    burst_check(32, 1'b0);
    in_valid = 1'b0;
    in_data  = '0;
    chk("ovf_dict0", dict[0], 'h200);
    chk("ovf_dict31", dict[31], 'h21F);
    chk("done_cnt_4", done_cnt, 4);

    // Reset on the 10th burst cycle of a 32-entry load.
    do_start();
    for (int i = 0; i < 32; i++) beat(10'('h300 + i), i == 31);
    for (int j = 0; j < 9; j++) begin
      chk("rb_we", write_enable, 1);
      chk("rb_val", write_val, 'h300 + j);
      @(negedge clk);
    end
    chk("rb_we10", write_enable, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rb_after_we", write_enable, 0);
    chk("rb_after_val", write_val, 0);
    chk("rb_after_busy", busy, 0);
    chk("rb_after_count", count, 0);
    chk("rb_after_done", done, 0);
    reset = 1'b0;
    done_before = done_cnt;
    repeat (4) @(negedge clk);
    chk("rb_no_done", done_cnt, done_before);
    chk("rb_idle_we", write_enable, 0);
    chk("rb_dict8", dict[8], 'h308);
    chk("rb_dict10", dict[10], 'h20A);
    chk("rb_dict31", dict[31], 'h21F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
